// File: rtl/complex_nr_mult_seq.sv
// Sequential complex multiplier: captures one operand pair over a valid/ready bus,
// forms the exact product with one shared signed multiplier in four steps, then hands the result off.
module complex_nr_mult_seq #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sw_rst,
    input  logic                      op_val,
    input  logic [4*DATA_WIDTH-1:0]   op_data,
    output logic                      op_ready,
    output logic                      res_val,
    input  logic                      res_ready,
    output logic [4*DATA_WIDTH+1:0]   res_data
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam int AW = PW + 1;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    state_t                       state;
    logic [1:0]                   step;
    logic signed [DATA_WIDTH-1:0] a_re, a_im, b_re, b_im;
    logic signed [DATA_WIDTH-1:0] mul_a, mul_b;
    logic signed [PW-1:0]         prod;
    logic signed [AW-1:0]         prod_ext;
    logic signed [AW-1:0]         re_acc, im_acc, im_sum;

    // Operand selection for the single shared multiplier, one partial product per step
    always_comb begin
        mul_a = a_re;
        mul_b = b_re;
        case (step)
            2'd0: begin mul_a = a_re; mul_b = b_re; end
            2'd1: begin mul_a = a_im; mul_b = b_im; end
            2'd2: begin mul_a = a_re; mul_b = b_im; end
            default: begin mul_a = a_im; mul_b = b_re; end
        endcase
    end

    assign prod     = mul_a * mul_b;
    assign prod_ext = {prod[PW-1], prod};
    assign im_sum   = im_acc + prod_ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            step     <= '0;
            op_ready <= 1'b0;
            res_val  <= 1'b0;
            res_data <= '0;
            a_re     <= '0;
            a_im     <= '0;
            b_re     <= '0;
            b_im     <= '0;
            re_acc   <= '0;
            im_acc   <= '0;
        end else if (sw_rst) begin
            state    <= IDLE;
            step     <= '0;
            op_ready <= 1'b0;
            res_val  <= 1'b0;
            res_data <= '0;
            a_re     <= '0;
            a_im     <= '0;
            b_re     <= '0;
            b_im     <= '0;
            re_acc   <= '0;
            im_acc   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    op_ready <= 1'b1;
                    if (op_val && op_ready) begin
                        {a_re, a_im, b_re, b_im} <= op_data;
                        op_ready <= 1'b0;
                        step     <= '0;
                        re_acc   <= '0;
                        im_acc   <= '0;
                        state    <= MUL;
                    end
                end
                MUL: begin
                    step <= step + 2'd1;
                    case (step)
                        2'd0: re_acc <= prod_ext;
                        2'd1: re_acc <= re_acc - prod_ext;
                        2'd2: im_acc <= prod_ext;
                        default: begin
                            // Final step folds directly into the output register
                            im_acc   <= im_sum;
                            res_data <= {re_acc, im_sum};
                            res_val  <= 1'b1;
                            state    <= DONE;
                        end
                    endcase
                end
                DONE: begin
                    if (res_ready) begin
                        res_val  <= 1'b0;
                        op_ready <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    op_ready <= 1'b0;
                    res_val  <= 1'b0;
                end
            endcase
        end
    end

endmodule
